// File: rtl/switch_pattern_decoder.sv
// switch_pattern_decoder: accepts 5-bit op/idx codes over valid/ready and
// rebuilds the 8-bit switch pattern they describe. After every accepted
// code the block stays busy for HOLD_CYCLES cycles so that each pattern
// remains visible before the next code is taken.
module switch_pattern_decoder #(
  parameter int HOLD_CYCLES = 4,   // legal range 1..255
  parameter int CNT_W       = 8    // minimum 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [7:0]       switch_out,
  output logic             update,
  output logic [CNT_W-1:0] update_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] OP_ONEHOT = 2'b00;
  localparam logic [1:0] OP_THERM  = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  state_t           state_reg;
  logic [7:0]       hold_cnt_reg;
  logic [7:0]       pattern_reg;
  logic [7:0]       pattern_next;
  logic             update_reg;
  logic [CNT_W-1:0] count_reg;

  logic [1:0] op;
  logic [2:0] idx;
  logic [7:0] onehot;
  logic [7:0] therm;

  assign op  = code_in[4:3];
  assign idx = code_in[2:0];

  // Per-bit decode of idx. Bit gi of (1 << idx) is set only when idx == gi,
  // and bit gi of ((2 << idx) - 1) is set whenever idx >= gi, so the 9-bit
  // shift-and-subtract form collapses to plain comparators here.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign onehot[gi] = (idx == 3'(gi));
      assign therm[gi]  = (idx >= 3'(gi));
    end
  endgenerate

  // Pattern that the current code would produce if accepted this cycle.
  always_comb begin
    pattern_next = pattern_reg;
    case (op)
      OP_ONEHOT: pattern_next = onehot;
      OP_THERM:  pattern_next = therm;
      OP_TOGGLE: pattern_next = pattern_reg ^ onehot;
      OP_CLEAR:  pattern_next = 8'h00;
      default:   pattern_next = pattern_reg;
    endcase
  end

  // Handshake FSM: accept in IDLE, then count down the hold interval.
  // Pattern, pulse and counter are all updated on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 8'd0;
      pattern_reg  <= 8'h00;
      update_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      update_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (code_valid) begin
            pattern_reg  <= pattern_next;
            update_reg   <= 1'b1;
            count_reg    <= count_reg + CNT_W'(1);
            hold_cnt_reg <= 8'(HOLD_CYCLES);
            state_reg    <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt_reg <= hold_cnt_reg - 8'd1;
          if (hold_cnt_reg == 8'd1) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Ready comes straight from the state register, never from code_valid.
  assign code_ready   = (state_reg == IDLE);
  assign switch_out   = pattern_reg;
  assign update       = update_reg;
  assign update_count = count_reg;

endmodule

// File: tb/tb_switch_pattern_decoder.sv
// Directed bench for switch_pattern_decoder. Instance u_dut uses the
// default parameters; u_dut_w uses CNT_W=2 for the counter-wrap test.
module tb_switch_pattern_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rst_n_w = 1'b0;
  logic [4:0] code_in = 5'd0;
  logic       code_valid = 1'b0;

  logic       code_ready, update;
  logic [7:0] switch_out, update_count;
  logic       code_ready_w, update_w;
  logic [7:0] switch_out_w;
  logic [1:0] update_count_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_pattern_decoder #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .switch_out(switch_out), .update(update),
    .update_count(update_count)
  );

  switch_pattern_decoder #(.HOLD_CYCLES(4), .CNT_W(2)) u_dut_w (
    .clk(clk), .rst_n(rst_n_w), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready_w), .switch_out(switch_out_w), .update(update_w),
    .update_count(update_count_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a code, wait (bounded) for ready, let one edge accept it and
  // return at the following falling edge with code_valid dropped.
  task automatic send(input logic [4:0] c, input bit w);
    int n;
    logic r;
    code_in    = c;
    code_valid = 1'b1;
    n = 0;
    r = w ? code_ready_w : code_ready;
    while (!r && n < 50) begin
      @(negedge clk);
      n++;
      r = w ? code_ready_w : code_ready;
    end
    check("send_ready", r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    if (w)
      $display("send w code=%b sw=%h upd=%0d cnt=%0d", c, switch_out_w, update_w, update_count_w);
    else
      $display("send code=%b sw=%h upd=%0d cnt=%0d", c, switch_out, update, update_count);
  endtask

  logic [4:0] bp_code [11];
  logic [7:0] bp_sw   [11];
  logic       bp_rdy  [11];

  initial begin
    int lowcnt;
    int n;

    // Reset values: drop rst_n between edges, outputs clear at once.
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sw", switch_out, 8'h00);
    check("rst_upd", update, 1'b0);
    check("rst_cnt", update_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", code_ready, 1'b1);

    // One-hot and hold interval.
    send(5'b00101, 1'b0);
    check("oh_sw", switch_out, 8'h20);
    check("oh_upd", update, 1'b1);
    check("oh_cnt", update_count, 8'd1);
    lowcnt = 0;
    while (!code_ready && lowcnt < 20) begin
      lowcnt++;
      @(negedge clk);
      if (lowcnt == 1) check("oh_upd_drop", update, 1'b0);
    end
    check("oh_hold_len", lowcnt, 4);

    // Thermometer bounds and clear.
    send(5'b01111, 1'b0);
    check("th7_sw", switch_out, 8'hFF);
    send(5'b01000, 1'b0);
    check("th0_sw", switch_out, 8'h01);
    send(5'b11101, 1'b0);
    check("clr_sw", switch_out, 8'h00);
    check("th_cnt", update_count, 8'd4);

    // Toggle sequence.
    send(5'b00101, 1'b0);
    check("tg_load", switch_out, 8'h20);
    send(5'b10000, 1'b0);
    check("tg_b0_on", switch_out, 8'h21);
    send(5'b10101, 1'b0);
    check("tg_b5_off", switch_out, 8'h01);
    send(5'b10000, 1'b0);
    check("tg_b0_off", switch_out, 8'h00);

    // Clear of an already-zero pattern still counts.
    send(5'b11000, 1'b0);
    check("clr0_sw", switch_out, 8'h00);
    check("clr0_upd", update, 1'b1);
    check("clr0_cnt", update_count, 8'd9);

    // Backpressure: valid held high, code changes every cycle. Only
    // entries 0, 5 and 10 land on ready edges.
    bp_code = '{5'b00011, 5'b11000, 5'b11000, 5'b01111, 5'b00111,
                5'b10000, 5'b01111, 5'b11000, 5'b00000, 5'b10011,
                5'b01010};
    bp_sw   = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08,
                8'h09, 8'h09, 8'h09, 8'h09, 8'h09,
                8'h07};
    bp_rdy  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b0};
    n = 0;
    while (!code_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_start_ready", code_ready, 1'b1);
    for (int i = 0; i < 11; i++) begin
      code_in    = bp_code[i];
      code_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      $display("bp cycle=%0d code=%b sw=%h rdy=%0d upd=%0d", i, bp_code[i], switch_out, code_ready, update);
      check($sformatf("bp_sw_%0d", i), switch_out, bp_sw[i]);
      check($sformatf("bp_rdy_%0d", i), code_ready, bp_rdy[i]);
      check($sformatf("bp_upd_%0d", i), update, (i % 5 == 0) ? 1'b1 : 1'b0);
    end
    code_valid = 1'b0;
    check("bp_cnt", update_count, 8'd12);

    // Counter wrap (CNT_W=2) and reset in the middle of a hold.
    rst_n_w = 1'b1;
    @(negedge clk);
    check("w_ready", code_ready_w, 1'b1);
    send(5'b00000, 1'b1);
    send(5'b00001, 1'b1);
    send(5'b00010, 1'b1);
    send(5'b00011, 1'b1);
    send(5'b00100, 1'b1);
    check("w_cnt_wrap", update_count_w, 2'd1);
    check("w_sw", switch_out_w, 8'h10);
    send(5'b01111, 1'b1);
    check("w_th_sw", switch_out_w, 8'hFF);
    check("w_th_cnt", update_count_w, 2'd2);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n_w = 1'b0;
    #1;
    check("w_rst_sw", switch_out_w, 8'h00);
    check("w_rst_cnt", update_count_w, 2'd0);
    check("w_rst_upd", update_w, 1'b0);
    @(negedge clk);
    rst_n_w = 1'b1;
    @(negedge clk);
    check("w_post_ready", code_ready_w, 1'b1);
    check("w_post_sw", switch_out_w, 8'h00);
    check("w_post_cnt", update_count_w, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
